// File: rtl/drive_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : drive_pkg
//  Brief    : Shared state encoding and saturation helper for the drive mixer.
//  Revision : 1.0 - initial release
// ============================================================================
package drive_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } drive_state_t;

    // Clamp a signed value into [0, 2^width-1]; the caller narrows the result.
    function automatic logic [31:0] sat_unsigned(input logic signed [31:0] value,
                                                 input int width);
        logic [31:0] w_max;
        w_max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (value < 0) begin
            return 32'd0;
        end
        if ($unsigned(value) > w_max) begin
            return w_max;
        end
        return $unsigned(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/slew_limiter.sv
`default_nettype none
// ============================================================================
//  Module   : slew_limiter
//  Brief    : Registered duty that moves toward its target by at most STEP
//             per tick; force_zero clears it immediately.
//  Revision : 1.0 - initial release
// ============================================================================
module slew_limiter #(
    parameter int W    = 17,
    parameter int STEP = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         force_zero,
    input  logic [W-1:0] target,
    output logic [W-1:0] duty
);

    localparam logic [W:0] c_STEP = (W+1)'(STEP);

    logic [W-1:0] r_duty;
    logic         w_rise;
    logic [W-1:0] w_dist;
    logic         w_near;
    logic [W-1:0] w_next;

    assign w_rise = target > r_duty;
    assign w_dist = w_rise ? (target - r_duty) : (r_duty - target);
    assign w_near = {1'b0, w_dist} <= c_STEP;
    assign w_next = w_near ? target
                  : (w_rise ? (r_duty + c_STEP[W-1:0]) : (r_duty - c_STEP[W-1:0]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_duty <= '0;
        end else if (force_zero) begin
            r_duty <= '0;
        end else if (tick) begin
            r_duty <= w_next;
        end
    end

    assign duty = r_duty;

endmodule
`default_nettype wire

// File: rtl/diff_drive_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : diff_drive_mixer
//  Brief    : Mixes base duty and clamped PID offset into slew-limited
//             left/right duties under a run/stop state machine.
//  Revision : 1.0 - initial release
// ============================================================================
module diff_drive_mixer
    import drive_pkg::*;
#(
    parameter int DUTY_W     = 17,
    parameter int OFF_W      = 18,
    parameter int MAX_OFFSET = 8192,
    parameter int SLEW_STEP  = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    toggle_req,
    input  logic                    fault,
    input  logic [DUTY_W-1:0]       base_duty,
    input  logic signed [OFF_W-1:0] offset,
    output logic [DUTY_W-1:0]       duty_l,
    output logic [DUTY_W-1:0]       duty_r,
    output logic                    motor_en,
    output logic [1:0]              state,
    output logic                    at_target
);

    localparam logic signed [OFF_W:0] c_MAX_OFF = (OFF_W+1)'(MAX_OFFSET);
    localparam logic [DUTY_W:0]       c_STEP    = (DUTY_W+1)'(SLEW_STEP);

    logic signed [OFF_W:0]    w_off_wide;
    logic signed [OFF_W:0]    w_off_c;
    logic signed [DUTY_W+1:0] w_base_ext;
    logic signed [DUTY_W+1:0] w_off_ext;
    logic signed [DUTY_W+1:0] w_sum_l;
    logic signed [DUTY_W+1:0] w_sum_r;

    logic [DUTY_W-1:0] w_tgt  [2];
    logic [DUTY_W-1:0] w_eff  [2];
    logic [DUTY_W-1:0] w_duty [2];
    logic [1:0]        w_near;
    logic              w_drive;

    drive_state_t r_state;
    drive_state_t w_state_nxt;
    logic         r_motor_en;

    assign w_off_wide = (OFF_W+1)'(offset);

    always_comb begin
        w_off_c = w_off_wide;
        if (w_off_wide > c_MAX_OFF) begin
            w_off_c = c_MAX_OFF;
        end else if (w_off_wide < -c_MAX_OFF) begin
            w_off_c = -c_MAX_OFF;
        end
    end

    assign w_base_ext = $signed({2'b00, base_duty});
    assign w_off_ext  = (DUTY_W+2)'(w_off_c);
    assign w_sum_l    = w_base_ext - w_off_ext;
    assign w_sum_r    = w_base_ext + w_off_ext;
    assign w_tgt[0]   = DUTY_W'(sat_unsigned(32'(w_sum_l), DUTY_W));
    assign w_tgt[1]   = DUTY_W'(sat_unsigned(32'(w_sum_r), DUTY_W));

    assign w_drive = (r_state == ST_RAMP_UP) || (r_state == ST_RUN);

    // Channel 0 is left, channel 1 is right; w_near means the next tick lands on target.
    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic [DUTY_W-1:0] w_dist;

        assign w_eff[g]  = w_drive ? w_tgt[g] : '0;
        assign w_dist    = (w_eff[g] > w_duty[g]) ? (w_eff[g] - w_duty[g])
                                                  : (w_duty[g] - w_eff[g]);
        assign w_near[g] = {1'b0, w_dist} <= c_STEP;

        slew_limiter #(
            .W    (DUTY_W),
            .STEP (SLEW_STEP)
        ) u_slew (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .force_zero (fault),
            .target     (w_eff[g]),
            .duty       (w_duty[g])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        if (fault) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (toggle_req) w_state_nxt = ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (toggle_req)              w_state_nxt = ST_RAMP_DOWN;
                    else if (tick && &w_near)    w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (toggle_req) w_state_nxt = ST_RAMP_DOWN;
                end
                ST_RAMP_DOWN: begin
                    if (toggle_req)              w_state_nxt = ST_RAMP_UP;
                    else if (tick && &w_near)    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_motor_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_motor_en <= (w_state_nxt != ST_IDLE);
        end
    end

    assign duty_l    = w_duty[0];
    assign duty_r    = w_duty[1];
    assign motor_en  = r_motor_en;
    assign state     = r_state;
    assign at_target = (w_duty[0] == w_eff[0]) && (w_duty[1] == w_eff[1]);

endmodule
`default_nettype wire

// File: tb/tb_diff_drive_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_diff_drive_mixer
//  Brief    : Directed self-checking bench for diff_drive_mixer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_diff_drive_mixer;

    logic               clk;
    logic               reset;
    logic               tick;
    logic               toggle_req;
    logic               fault;
    logic [16:0]        base_duty;
    logic signed [17:0] offset;
    logic [16:0]        duty_l;
    logic [16:0]        duty_r;
    logic               motor_en;
    logic [1:0]         state;
    logic               at_target;

    int total = 0;
    int bad   = 0;

    diff_drive_mixer #(
        .DUTY_W     (17),
        .OFF_W      (18),
        .MAX_OFFSET (8192),
        .SLEW_STEP  (1024)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .toggle_req (toggle_req),
        .fault      (fault),
        .base_duty  (base_duty),
        .offset     (offset),
        .duty_l     (duty_l),
        .duty_r     (duty_r),
        .motor_en   (motor_en),
        .state      (state),
        .at_target  (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic do_toggle();
        toggle_req = 1'b1;
        step();
        toggle_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; toggle_req = 1'b0; fault = 1'b0;
        base_duty = 17'd16384; offset = 18'sd0;
        step(); step();
        check("rst_duty_l", 32'(duty_l), 32'd0);
        check("rst_duty_r", 32'(duty_r), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_motor_en", 32'(motor_en), 32'd0);
        reset = 1'b0;
        step();

        // Soft start to 16384
        do_toggle();
        check("start_state", 32'(state), 32'd1);
        check("start_motor_en", 32'(motor_en), 32'd1);
        check("start_duty", 32'(duty_l), 32'd0);
        do_tick();
        check("ramp1_duty_l", 32'(duty_l), 32'd1024);
        check("ramp1_duty_r", 32'(duty_r), 32'd1024);
        for (int i = 2; i <= 15; i++) do_tick();
        check("ramp15_duty", 32'(duty_r), 32'd15360);
        check("ramp15_state", 32'(state), 32'd1);
        do_tick();
        check("ramp16_duty", 32'(duty_l), 32'd16384);
        check("ramp16_state", 32'(state), 32'd2);
        check("ramp16_at_target", 32'(at_target), 32'd1);

        // Positive offset clamped to 8192
        offset = 18'sd20000;
        for (int i = 1; i <= 7; i++) do_tick();
        check("pos7_duty_r", 32'(duty_r), 32'd23552);
        check("pos7_duty_l", 32'(duty_l), 32'd9216);
        check("pos7_at_target", 32'(at_target), 32'd0);
        do_tick();
        check("pos8_duty_r", 32'(duty_r), 32'd24576);
        check("pos8_duty_l", 32'(duty_l), 32'd8192);
        check("pos8_state", 32'(state), 32'd2);

        // Negative offset mirrors
        offset = -18'sd20000;
        for (int i = 1; i <= 16; i++) do_tick();
        check("neg_duty_r", 32'(duty_r), 32'd8192);
        check("neg_duty_l", 32'(duty_l), 32'd24576);

        // Saturation at the top of the duty range
        base_duty = 17'd130000; offset = 18'sd8192;
        for (int i = 1; i <= 125; i++) do_tick();
        check("sat_duty_r", 32'(duty_r), 32'd131071);
        check("sat_duty_l", 32'(duty_l), 32'd121808);
        check("sat_at_target", 32'(at_target), 32'd1);

        // Fault from RUN
        fault = 1'b1;
        step();
        check("fault_run_state", 32'(state), 32'd0);
        check("fault_run_duty_r", 32'(duty_r), 32'd0);
        fault = 1'b0;
        step();

        // Fault during RAMP_UP at 5120, coincident with a tick
        base_duty = 17'd16384; offset = 18'sd0;
        do_toggle();
        for (int i = 1; i <= 5; i++) do_tick();
        check("pre_fault_duty", 32'(duty_l), 32'd5120);
        check("pre_fault_state", 32'(state), 32'd1);
        fault = 1'b1; tick = 1'b1;
        step();
        tick = 1'b0;
        check("fault_duty_l", 32'(duty_l), 32'd0);
        check("fault_duty_r", 32'(duty_r), 32'd0);
        check("fault_state", 32'(state), 32'd0);
        check("fault_motor_en", 32'(motor_en), 32'd0);
        do_toggle();
        check("fault_toggle_state", 32'(state), 32'd0);
        fault = 1'b0;
        step();
        check("fault_drop_state", 32'(state), 32'd0);
        check("fault_drop_motor_en", 32'(motor_en), 32'd0);

        // Ramp up, ramp down, reversal
        do_toggle();
        for (int i = 1; i <= 16; i++) do_tick();
        check("rerun_state", 32'(state), 32'd2);
        do_toggle();
        check("down_state", 32'(state), 32'd3);
        check("down_motor_en", 32'(motor_en), 32'd1);
        for (int i = 1; i <= 8; i++) do_tick();
        check("down8_duty", 32'(duty_l), 32'd8192);
        check("down8_state", 32'(state), 32'd3);
        do_toggle();
        check("rev_state", 32'(state), 32'd1);
        check("rev_duty", 32'(duty_r), 32'd8192);
        do_tick();
        check("rev_tick_duty", 32'(duty_r), 32'd9216);
        toggle_req = 1'b1; tick = 1'b1;
        step();
        toggle_req = 1'b0; tick = 1'b0;
        check("coinc_duty", 32'(duty_l), 32'd10240);
        check("coinc_state", 32'(state), 32'd3);
        do_tick();
        check("coinc_next_duty", 32'(duty_l), 32'd9216);

        // Asynchronous reset mid RAMP_DOWN
        #3 reset = 1'b1;
        #1;
        check("areset_duty_l", 32'(duty_l), 32'd0);
        check("areset_duty_r", 32'(duty_r), 32'd0);
        check("areset_state", 32'(state), 32'd0);
        check("areset_motor_en", 32'(motor_en), 32'd0);
        reset = 1'b0;
        do_tick();
        check("idle_tick_duty", 32'(duty_r), 32'd0);
        check("idle_tick_state", 32'(state), 32'd0);
        check("idle_at_target", 32'(at_target), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
